// File: rtl/stopwatch_pkg.sv
// Shared state encoding, control-output decode and button-priority helper for the stopwatch lap controller.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_SPLIT = 2'd2,
    ST_PAUSE = 2'd3
  } sw_state_e;

  typedef struct packed {
    logic en;
    logic clr;
    logic freeze;
  } sw_ctrl_t;

  typedef struct packed {
    logic start;
    logic stop;
    logic lap;
  } sw_btn_t;

  localparam sw_ctrl_t CTRL_IDLE  = '{en: 1'b0, clr: 1'b1, freeze: 1'b0};
  localparam sw_ctrl_t CTRL_RUN   = '{en: 1'b1, clr: 1'b0, freeze: 1'b0};
  localparam sw_ctrl_t CTRL_SPLIT = '{en: 1'b1, clr: 1'b0, freeze: 1'b1};
  localparam sw_ctrl_t CTRL_PAUSE = '{en: 1'b0, clr: 1'b0, freeze: 1'b0};

  function automatic sw_ctrl_t decode_ctrl(input sw_state_e s);
    sw_ctrl_t c;
    case (s)
      ST_RUN:   c = CTRL_RUN;
      ST_SPLIT: c = CTRL_SPLIT;
      ST_PAUSE: c = CTRL_PAUSE;
      default:  c = CTRL_IDLE;
    endcase
    return c;
  endfunction

  // Only the highest-priority edge survives: stop > lap > start.
  function automatic sw_btn_t prioritize(input sw_btn_t raw);
    sw_btn_t ev;
    ev.stop  = raw.stop;
    ev.lap   = raw.lap & ~raw.stop;
    ev.start = raw.start & ~raw.stop & ~raw.lap;
    return ev;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for a debounced level button; the history bit resets high so a
// button held through reset never produces a spurious edge.
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= btn_i;
    end
  end

  assign rise_o = btn_i & ~prev_q;

endmodule

// File: rtl/stopwatch_lap_ctrl.sv
// Stopwatch controller with button edge detection, split/lap display freeze and a lap buffer.
// Define STOPWATCH_LAP_DELTA_EN to store lap deltas instead of absolute times in the buffer.
module stopwatch_lap_ctrl
  import stopwatch_pkg::*;
#(
  parameter  int TIME_W    = 24,
  parameter  int LAP_DEPTH = 8,
  localparam int CNT_W     = $clog2(LAP_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_b,
  input  logic              stop_b,
  input  logic              lap_b,
  input  logic [TIME_W-1:0] time_i,
  output logic              en,
  output logic              clr,
  output logic              freeze,
  output logic [TIME_W-1:0] hold_time,
  output logic [CNT_W-1:0]  lap_count,
  output logic              lap_full,
  output logic              lap_ovf,
  input  logic [CNT_W-1:0]  rd_idx,
  output logic [TIME_W-1:0] rd_data
);

  localparam int IDX_W = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(LAP_DEPTH);

  sw_btn_t   raw_edge;
  sw_btn_t   ev;
  sw_state_e state_q, state_d;
  sw_ctrl_t  ctrl;

  btn_edge u_start_edge (.clk(clk), .rst_n(rst_n), .btn_i(start_b), .rise_o(raw_edge.start));
  btn_edge u_stop_edge  (.clk(clk), .rst_n(rst_n), .btn_i(stop_b),  .rise_o(raw_edge.stop));
  btn_edge u_lap_edge   (.clk(clk), .rst_n(rst_n), .btn_i(lap_b),   .rise_o(raw_edge.lap));

  assign ev = prioritize(raw_edge);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (ev.start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (ev.stop)     state_d = ST_PAUSE;
        else if (ev.lap) state_d = ST_SPLIT;
      end
      ST_SPLIT: begin
        if (ev.stop)     state_d = ST_PAUSE;
        else if (ev.lap) state_d = ST_RUN;
      end
      ST_PAUSE: begin
        if (ev.start)     state_d = ST_RUN;
        else if (ev.stop) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ctrl   = decode_ctrl(state_q);
    en     = ctrl.en;
    clr    = ctrl.clr;
    freeze = ctrl.freeze;
  end

  // Lap datapath: capture on RUN+lap, wipe on PAUSE+stop.
  logic              capture, clear, wr_en;
  logic [TIME_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [TIME_W-1:0] slot_wdata;

  assign capture  = (state_q == ST_RUN) && ev.lap;
  assign clear    = (state_q == ST_PAUSE) && ev.stop;
  assign lap_full = (cnt_q == DEPTH_C);
  assign wr_en    = capture && !lap_full;

`ifdef STOPWATCH_LAP_DELTA_EN
  logic [TIME_W-1:0] prev_cap_q, prev_cap_d;

  always_comb begin
    prev_cap_d = prev_cap_q;
    if (clear)        prev_cap_d = '0;
    else if (capture) prev_cap_d = time_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_cap_q <= '0;
    end else begin
      prev_cap_q <= prev_cap_d;
    end
  end

  assign slot_wdata = time_i - prev_cap_q;
`else
  assign slot_wdata = time_i;
`endif

  always_comb begin
    hold_d = hold_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    if (clear) begin
      hold_d = '0;
      cnt_d  = '0;
      ovf_d  = 1'b0;
    end else if (capture) begin
      hold_d = time_i;
      if (lap_full) ovf_d = 1'b1;
      else          cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  assign hold_time = hold_q;
  assign lap_count = cnt_q;
  assign lap_ovf   = ovf_q;

  // Slot storage is deliberately unreset; a cleared buffer only drops the count.
  logic [TIME_W-1:0] slot_q [LAP_DEPTH];
  logic [IDX_W-1:0]  wr_addr, rd_addr;
  logic              rd_hit;
  logic [TIME_W-1:0] rd_data_q;

  assign wr_addr = cnt_q[IDX_W-1:0];
  assign rd_addr = rd_idx[IDX_W-1:0];
  assign rd_hit  = (rd_idx < DEPTH_C);

  always_ff @(posedge clk) begin
    if (wr_en) slot_q[wr_addr] <= slot_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_hit ? slot_q[rd_addr] : '0;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Directed bench for stopwatch_lap_ctrl (TIME_W=8, LAP_DEPTH=2); expectations follow STOPWATCH_LAP_DELTA_EN.
module tb_stopwatch_lap_ctrl;

  localparam int TIME_W    = 8;
  localparam int LAP_DEPTH = 2;
  localparam int CNT_W     = $clog2(LAP_DEPTH + 1);
`ifdef STOPWATCH_LAP_DELTA_EN
  localparam bit DELTA = 1'b1;
`else
  localparam bit DELTA = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start_b, stop_b, lap_b;
  logic [TIME_W-1:0] time_i;
  logic              en, clr, freeze;
  logic [TIME_W-1:0] hold_time;
  logic [CNT_W-1:0]  lap_count;
  logic              lap_full, lap_ovf;
  logic [CNT_W-1:0]  rd_idx;
  logic [TIME_W-1:0] rd_data;

  int errors = 0;
  int checks = 0;

  stopwatch_lap_ctrl #(.TIME_W(TIME_W), .LAP_DEPTH(LAP_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_b(start_b), .stop_b(stop_b), .lap_b(lap_b),
    .time_i(time_i),
    .en(en), .clr(clr), .freeze(freeze),
    .hold_time(hold_time), .lap_count(lap_count),
    .lap_full(lap_full), .lap_ovf(lap_ovf),
    .rd_idx(rd_idx), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic press_lap(input logic [TIME_W-1:0] t);
    time_i = t;
    lap_b  = 1'b1;
    step();
  endtask

  initial begin
    rst_n = 1'b0; start_b = 1'b1; stop_b = 1'b0; lap_b = 1'b0;
    time_i = '0; rd_idx = '0;
    step(); step();
    chk("rst_clr", clr, 1); chk("rst_en", en, 0); chk("rst_freeze", freeze, 0);
    chk("rst_hold", hold_time, 0); chk("rst_cnt", lap_count, 0);
    chk("rst_full", lap_full, 0); chk("rst_ovf", lap_ovf, 0); chk("rst_rd", rd_data, 0);
    $display("reset checked");

    // start held through reset: no edge
    rst_n = 1'b1;
    step(); step();
    chk("held_start_clr", clr, 1); chk("held_start_en", en, 0);
    $display("held start: en=%0d clr=%0d", en, clr);

    start_b = 1'b0; step();
    start_b = 1'b1; step();
    chk("start_en", en, 1); chk("start_clr", clr, 0);
    start_b = 1'b0;
    $display("start: en=%0d", en);

    press_lap(8'd100);
    chk("lap1_freeze", freeze, 1); chk("lap1_hold", hold_time, 100); chk("lap1_cnt", lap_count, 1);
    lap_b = 1'b0; step();
    rd_idx = 0; step();
    chk("lap1_slot0", rd_data, 100);
    $display("lap @100: hold=%0d cnt=%0d slot0=%0d", hold_time, lap_count, rd_data);

    press_lap(8'd110);
    chk("split_exit_freeze", freeze, 0); chk("split_exit_en", en, 1);
    chk("split_exit_cnt", lap_count, 1); chk("split_exit_hold", hold_time, 100);
    lap_b = 1'b0; step();
    $display("split exit: freeze=%0d cnt=%0d", freeze, lap_count);

    // stop and lap together in RUN: stop wins
    time_i = 8'd120; stop_b = 1'b1; lap_b = 1'b1; step();
    chk("stoplap_en", en, 0); chk("stoplap_freeze", freeze, 0); chk("stoplap_clr", clr, 0);
    chk("stoplap_cnt", lap_count, 1); chk("stoplap_hold", hold_time, 100);
    stop_b = 1'b0; lap_b = 1'b0; step();
    stop_b = 1'b1; step();
    chk("clear_clr", clr, 1); chk("clear_cnt", lap_count, 0);
    chk("clear_ovf", lap_ovf, 0); chk("clear_hold", hold_time, 0);
    stop_b = 1'b0; step();
    $display("stop+lap then stop: clr=%0d cnt=%0d", clr, lap_count);

    // fill and overflow the two-slot buffer
    start_b = 1'b1; step(); start_b = 1'b0;
    chk("restart_en", en, 1);
    press_lap(8'd10); lap_b = 1'b0; step();
    press_lap(8'd15); lap_b = 1'b0; step();
    press_lap(8'd20);
    chk("fill_cnt", lap_count, 2); chk("fill_full", lap_full, 1); chk("fill_ovf", lap_ovf, 0);
    lap_b = 1'b0; step();
    press_lap(8'd25); lap_b = 1'b0; step();
    press_lap(8'd30);
    chk("ovf_flag", lap_ovf, 1); chk("ovf_full", lap_full, 1); chk("ovf_cnt", lap_count, 2);
    chk("ovf_hold", hold_time, 30); chk("ovf_freeze", freeze, 1);
    lap_b = 1'b0; step();
    rd_idx = 0; step(); chk("full_slot0", rd_data, 10);
    rd_idx = 1; step(); chk("full_slot1", rd_data, DELTA ? 10 : 20);
    $display("overflow: cnt=%0d full=%0d ovf=%0d slot1=%0d", lap_count, lap_full, lap_ovf, rd_data);

    // clear, then laps at 50 and 80 with a same-cycle read/write of slot 0
    stop_b = 1'b1; step(); stop_b = 1'b0; step();
    stop_b = 1'b1; step();
    chk("clear2_ovf", lap_ovf, 0); chk("clear2_full", lap_full, 0); chk("clear2_cnt", lap_count, 0);
    stop_b = 1'b0; step();
    start_b = 1'b1; step(); start_b = 1'b0; step();
    rd_idx = 0;
    press_lap(8'd50);
    chk("rw_same_old", rd_data, 10); chk("lap50_hold", hold_time, 50);
    lap_b = 1'b0; step();
    chk("rw_same_new", rd_data, 50);
    press_lap(8'd60); lap_b = 1'b0; step();
    press_lap(8'd80);
    chk("lap80_cnt", lap_count, 2); chk("lap80_hold", hold_time, 80);
    lap_b = 1'b0; step();
    rd_idx = 1; step(); chk("lap80_slot1", rd_data, DELTA ? 30 : 80);
    $display("laps 50/80: slot1=%0d", rd_data);

    // wrapped delta: 250 then 4
    stop_b = 1'b1; step(); stop_b = 1'b0; step();
    stop_b = 1'b1; step(); stop_b = 1'b0; step();
    start_b = 1'b1; step(); start_b = 1'b0; step();
    press_lap(8'd250); lap_b = 1'b0; step();
    press_lap(8'd0);   lap_b = 1'b0; step();
    press_lap(8'd4);
    chk("wrap_hold", hold_time, 4); chk("wrap_freeze", freeze, 1);
    lap_b = 1'b0; step();
    rd_idx = 1; step(); chk("wrap_slot1", rd_data, DELTA ? 10 : 4);
    rd_idx = 0; step(); chk("wrap_slot0", rd_data, 250);
    $display("wrap 250->4: slot0=%0d", rd_data);

    // asynchronous reset while in SPLIT
    #2; rst_n = 1'b0; #1;
    chk("async_en", en, 0); chk("async_freeze", freeze, 0); chk("async_clr", clr, 1);
    chk("async_cnt", lap_count, 0); chk("async_hold", hold_time, 0);
    chk("async_full", lap_full, 0); chk("async_rd", rd_data, 0);
    step(); rst_n = 1'b1;
    rd_idx = 1; step(); chk("kept_slot1", rd_data, DELTA ? 10 : 4);
    rd_idx = CNT_W'(LAP_DEPTH); step(); chk("oob_rd", rd_data, 0);
    $display("async reset + out-of-range read: rd=%0d", rd_data);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_lap_ctrl.md
Name: stopwatch_lap_ctrl

Overview:
- Next-generation stopwatch controller.
- Adds rising-edge button detection, a split/lap state with display freeze, and a parametrised on-chip lap buffer.
- Sits between the debounced button inputs and the time counter/display path; drives counter enable/clear and supplies captured lap times for readback.

Parameters:
- TIME_W, 24, width of the time value from the counter.
- LAP_DEPTH, 8, number of lap slots (>=1).
- CNT_W, $clog2(LAP_DEPTH+1), lap-count width (derived, not overridable).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start_b  in  1  debounced start/resume button, level.
- stop_b  in  1  debounced stop/reset button, level.
- lap_b  in  1  debounced lap/split button, level.
- time_i  in  TIME_W  current counter value.
- en  out  1  counter enable.
- clr  out  1  counter clear.
- freeze  out  1  display shows hold_time instead of time_i.
- hold_time  out  TIME_W  last captured time (registered).
- lap_count  out  CNT_W  number of valid lap slots.
- lap_full  out  1  lap_count == LAP_DEPTH.
- lap_ovf  out  1  sticky: lap pressed while full.
- rd_idx  in  CNT_W  lap slot to read.
- rd_data  out  TIME_W  slot contents, registered.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Edge detect: per button, prev register resets to 1; edge = btn & ~prev. A button held through reset produces no edge.
- Edge priority in the same cycle: stop > lap > start. Only the highest-priority edge acts.
- Latency: state updates on the clock edge that first samples a button at 1. Outputs are decoded combinationally from state (en, clr, freeze) or registered (hold_time, lap_count, flags), so they are valid right after that edge.
- States:
  - IDLE: clr=1, en=0, freeze=0.
  - RUN: en=1.
  - SPLIT: en=1, freeze=1.
  - PAUSE: en=0, freeze=0.
  - Unused encodings go to IDLE.
- Transitions:
  - IDLE: start -> RUN. Lap and stop are ignored.
  - RUN: stop -> PAUSE. lap -> SPLIT and capture.
  - SPLIT: lap -> RUN, no capture. stop -> PAUSE. start is ignored.
  - PAUSE: start -> RUN. stop -> IDLE and clear lap buffer. lap is ignored.
- Capture (RUN + lap edge):
  - hold_time <= time_i.
  - If !lap_full: slot[lap_count] <= stored value, lap_count++.
  - If lap_full: no write, count held, lap_ovf <= 1; the transition to SPLIT still occurs.
- Clear (PAUSE + stop edge): lap_count <= 0, lap_ovf <= 0, hold_time <= 0. Slot contents are not cleared.
- Readback:
  - rd_data <= slot[rd_idx] one cycle after rd_idx is presented.
  - rd_idx >= LAP_DEPTH returns 0.
  - A write and a read of the same slot in the same cycle returns the old value.
- Reset values:
  - State IDLE (clr=1, en=0, freeze=0).
  - hold_time=0, lap_count=0, lap_full=0, lap_ovf=0, rd_data=0.
  - Slot contents are not reset.
- Reset asserted mid-operation returns to IDLE immediately, with all of the above values.

Optional Feature:
- Macro STOPWATCH_LAP_DELTA_EN.
- Defined:
  - Slots store time_i minus the previous capture, modulo 2^TIME_W.
  - The previous-capture register resets to 0 and clears with the lap buffer.
  - hold_time still shows absolute time_i.
- Undefined: slots store absolute time_i; no previous-capture register is built.

Decomposition:
- Package stopwatch_pkg:
  - State typedef (IDLE, RUN, SPLIT, PAUSE) as a 2-bit enum.
  - Shared encodings so the display mux and control logic agree.
- Sub-module btn_edge (prev register reset-to-1 plus edge output), instantiated three times.
- Lap buffer is an inline register array.

Test Plan:
- Reset with start_b held 1, release reset, keep start_b=1 -> stays IDLE, clr=1. Drop start_b to 0 then raise it -> en=1 right after the sampling edge.
- RUN, time_i=100 then lap -> SPLIT, freeze=1, hold_time=100, lap_count=1, slot0=100. Lap again -> RUN, freeze=0, lap_count stays 1.
- LAP_DEPTH=2, three laps at time_i=10/20/30 (returning to RUN between) -> lap_full=1, lap_ovf=1, slots 10/20, hold_time=30.
- RUN with stop and lap rising in the same cycle -> PAUSE, no capture, lap_count unchanged. In PAUSE, stop -> IDLE, lap_count=0, lap_ovf=0.
- With STOPWATCH_LAP_DELTA_EN, laps at time_i=50 and 80 -> slot0=50, slot1=30. A wrapped case with TIME_W=8 (250 then 4) stores 10.
- Assert rst_n mid-SPLIT -> en=0, freeze=0, clr=1, lap_count=0 immediately. rd_idx=LAP_DEPTH -> rd_data=0 one cycle later.
